// File: rtl/cmp_eq_stim_checker_pkg.sv
// Shared types for the equality-comparator stimulus checker: FSM states,
// expected-entry record and the sweep-size helper.
package cmp_pkg;

  // Entries are sized for the widest supported operand; narrower builds zero-extend.
  localparam int unsigned CmpMaxWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } cmp_drv_state_t;

  typedef struct packed {
    logic                   valid;
    logic [CmpMaxWidth-1:0] a;
    logic [CmpMaxWidth-1:0] b;
    logic                   exp;
  } cmp_exp_entry_t;

  function automatic int unsigned cmp_num_vec(int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/cmp_eq_stim_checker_if.sv
// Operand/response bus between the stimulus checker and the comparator under test.
interface cmp_eq_stim_checker_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             vec_valid;
  logic             eq_in;

  modport master (
    output a_out,
    output b_out,
    output vec_valid,
    input  eq_in
  );

  modport slave (
    input  a_out,
    input  b_out,
    input  vec_valid,
    output eq_in
  );
endinterface

// File: rtl/cmp_eq_stim_checker_exp_pipe.sv
// Delay line of expected entries matching the comparator's response latency;
// a plain wire when DEPTH is 0.
module cmp_exp_pipe
  import cmp_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  cmp_exp_entry_t head_i,
  output cmp_exp_entry_t tail_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign tail_o = head_i;
  end else begin : g_stages
    cmp_exp_entry_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= head_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign tail_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/cmp_eq_stim_checker.sv
// Exhaustive operand sweep and response checker for one equality comparator.
// Optional CMP_EQ_STIM_HOLD_EN adds a hold input that stalls the sweep with bubbles.
module cmp_eq_stim_checker
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned RESP_LAT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef CMP_EQ_STIM_HOLD_EN
  input  logic                        hold,
`endif
  cmp_eq_stim_checker_if.master       vec,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [2*WIDTH:0]            err_count,
  output logic [WIDTH-1:0]            fail_a,
  output logic [WIDTH-1:0]            fail_b
);

  localparam int unsigned    VecW      = 2 * WIDTH;
  localparam int unsigned    ErrW      = 2 * WIDTH + 1;
  localparam int unsigned    NumVec    = cmp_num_vec(WIDTH);
  localparam logic [VecW-1:0] IdxLast  = VecW'(NumVec - 1);
  localparam logic [ErrW-1:0] ErrMax   = '1;
  localparam logic [1:0]     DrainLast = (RESP_LAT == 0) ? 2'd0 : 2'(RESP_LAT - 1);

  cmp_drv_state_t   state_q, state_d;
  logic [VecW-1:0]  idx_q, idx_d;
  logic [ErrW-1:0]  err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             first_q, first_d;
  logic [1:0]       drain_q, drain_d;

  logic             hold_eff;
  logic             issue;
  logic             mismatch;
  cmp_exp_entry_t   head;
  cmp_exp_entry_t   tail;

`ifdef CMP_EQ_STIM_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  // A held RUN cycle issues a bubble; operands simply keep the current idx.
  assign issue = (state_q == RUN) && !hold_eff;

  always_comb begin
    head       = '0;
    head.valid = issue;
    head.a     = CmpMaxWidth'(idx_q[WIDTH-1:0]);
    head.b     = CmpMaxWidth'(idx_q[VecW-1:WIDTH]);
    head.exp   = (idx_q[WIDTH-1:0] == idx_q[VecW-1:WIDTH]);
  end

  cmp_exp_pipe #(
    .DEPTH (RESP_LAT)
  ) u_exp_pipe (
    .clk    (clk),
    .rst    (rst),
    .head_i (head),
    .tail_o (tail)
  );

  if (WIDTH < CmpMaxWidth) begin : g_unused_hi
    logic unused_tail_hi;
    assign unused_tail_hi = ^{tail.a[CmpMaxWidth-1:WIDTH], tail.b[CmpMaxWidth-1:WIDTH]};
  end

  assign mismatch = tail.valid && (vec.eq_in != tail.exp);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    first_d  = first_q;
    drain_d  = drain_q;

    if (mismatch) begin
      if (err_q != ErrMax) begin
        err_d = err_q + 1'b1;
      end
      if (!first_q) begin
        first_d  = 1'b1;
        fail_a_d = tail.a[WIDTH-1:0];
        fail_b_d = tail.b[WIDTH-1:0];
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          idx_d    = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          first_d  = 1'b0;
        end
      end
      RUN: begin
        if (!hold_eff) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = (RESP_LAT == 0) ? DONE : DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DrainLast) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      first_q  <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      first_q  <= first_d;
      drain_q  <= drain_d;
    end
  end

  assign vec.a_out     = idx_q[WIDTH-1:0];
  assign vec.b_out     = idx_q[VecW-1:WIDTH];
  assign vec.vec_valid = issue;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule
